osc_phase_gen: RTL and testbench
================================

OSC_PHASE_GEN -- requirements
Module: osc_phase_gen

Interface
REQ-001 Parameter NUM_PHASES, default 4, number of non-overlapping phase outputs (1..8).
REQ-002 Parameter CNT_W, default 8, width of period/high-time fields and internal counters.
REQ-003 Parameter DEF_PERIOD, default 10, period in clk cycles loaded at reset.
REQ-004 Parameter DEF_HIGH, default 2, per-phase high time in clk cycles loaded at reset.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  level; request oscillation.
REQ-008 oneshot  input  1  level; sampled at start, 1 = run exactly one period then stop.
REQ-009 cfg_load  input  1  pulse; capture period_in/high_in into shadow config.
REQ-010 period_in  input  CNT_W  requested period P in cycles.
REQ-011 high_in  input  CNT_W  requested per-phase high time H in cycles.
REQ-012 phase  output  NUM_PHASES  registered phase pulses, at most one bit high.
REQ-013 tick  output  1  one-cycle strobe in the first cycle of every period.
REQ-014 busy  output  1  high in RUN and STOP states.
REQ-015 done  output  1  one-cycle strobe when returning to IDLE from STOP.
REQ-016 cfg_err  output  1  sticky flag, set on rejected cfg_load, cleared by the next accepted load.

Function
REQ-017 States SHALL be IDLE, RUN, STOP; IDLE->RUN on enable; RUN->STOP on enable low or oneshot period end; STOP->IDLE at period end.
REQ-018 Period counter cnt SHALL count 0..P-1 in RUN/STOP and wrap to 0; tick=1 exactly when cnt==0.
REQ-019 Phase k SHALL be high for cnt in [k*H, (k+1)*H-1], k=0..NUM_PHASES-1; all phases low for cnt >= NUM_PHASES*H.
REQ-020 Phase timing SHALL use a sub-counter (0..H-1) and phase index, no multiplier.
REQ-021 Latency: enable sampled high in IDLE at edge t -> tick=1 and phase[0]=1 from edge t+1.
REQ-022 enable low mid-period SHALL complete the current period; no truncated pulse; done in the cycle after the last period cycle.
REQ-023 oneshot=1 at start SHALL produce exactly one period, then STOP->IDLE with done, regardless of enable.
REQ-024 enable re-asserted during STOP SHALL NOT cancel the stop; restart only from IDLE.
REQ-025 cfg_load SHALL be rejected (cfg_err=1, shadow unchanged) if P<2, H==0, or NUM_PHASES*H > P.
REQ-026 Accepted shadow config SHALL become active only at a period boundary (cnt wrap) or on IDLE->RUN; never mid-period.
REQ-027 cfg_load and period wrap in the same cycle: the new config SHALL apply at the following boundary.
REQ-028 Arithmetic check NUM_PHASES*H SHALL use CNT_W+3 bits; no overflow aliasing.
REQ-029 In IDLE all phase bits, tick, busy SHALL be 0.

Reset
REQ-030 reset SHALL force IDLE, cnt=0, phase=0, tick=0, busy=0, done=0, cfg_err=0, active and shadow config = DEF_PERIOD/DEF_HIGH.
REQ-031 reset asserted mid-period SHALL drive all outputs 0 at the next edge, with no completion of the period.
REQ-032 Invalid default parameters (NUM_PHASES*DEF_HIGH > DEF_PERIOD) SHALL be an elaboration error.

Structure
REQ-033 Package osc_pkg SHALL hold the state enum (IDLE, RUN, STOP), MAX_PHASES=8, and the config struct {period, high}.
REQ-034 One sub-module osc_phase_seq SHALL hold sub-counter, phase index and phase decode; top holds FSM, cnt, config.

Verification
REQ-035 Defaults (P=10,H=2,N=4), enable held: phases 0..3 each 2 cycles high at cnt 0-1,2-3,4-5,6-7; all low for cnt 8-9; tick every 10 cycles.
REQ-036 Drop enable at cnt=3: phase[1] finishes, phases 2,3 still pulse, done at cycle after cnt=9, busy low thereafter.
REQ-037 oneshot=1 with enable held: exactly one tick, one pulse per phase, done once, then IDLE.
REQ-038 cfg_load P=8,H=3 (12>8): cfg_err=1, timing unchanged; then P=16,H=3: cfg_err=0, new timing from next tick.
REQ-039 reset at cnt=5 in RUN: next edge all outputs 0, state IDLE; restart gives tick in the cycle after enable.
REQ-040 Random cfg_load/enable/oneshot: assertions — at most one phase bit high, no pulse shorter than H, tick only at cnt==0.

Source files
------------

// File: rtl/osc_pkg.sv
// rtl/osc_pkg.sv - shared types and limits for the multi-phase oscillator
package osc_pkg;

  localparam int MAX_PHASES = 8;
  localparam int MAX_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } osc_state_e;

  typedef struct packed {
    logic [MAX_CNT_W-1:0] period;
    logic [MAX_CNT_W-1:0] high;
  } osc_cfg_t;

endpackage

// File: rtl/osc_phase_seq.sv
// rtl/osc_phase_seq.sv - sub-counter and phase index producing one-hot phase pulses
module osc_phase_seq
  import osc_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  restart,
  input  logic [MAX_CNT_W-1:0]  high,
  output logic [NUM_PHASES-1:0] phase
);

  localparam int IDX_W = 4;

  logic [CNT_W-1:0]      sub_q, sub_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_PHASES-1:0] phase_q, phase_d;
  logic                  sub_wrap;

  assign sub_wrap = (MAX_CNT_W'(sub_q) == high - MAX_CNT_W'(1));

  always_comb begin
    sub_d   = sub_q;
    idx_d   = idx_q;
    phase_d = '0;
    if (!run || restart) begin
      sub_d = '0;
      idx_d = '0;
    end else if (idx_q != IDX_W'(NUM_PHASES)) begin
      // index saturates at NUM_PHASES so the tail of the period stays quiet
      if (sub_wrap) begin
        sub_d = '0;
        idx_d = idx_q + 1'b1;
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end
    if (run && (idx_d < IDX_W'(NUM_PHASES))) begin
      phase_d = NUM_PHASES'(1) << idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sub_q   <= '0;
      idx_q   <= '0;
      phase_q <= '0;
    end else begin
      sub_q   <= sub_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/osc_phase_gen.sv
// rtl/osc_phase_gen.sv - run/stop FSM, period counter and shadowed config for the phase generator
module osc_phase_gen
  import osc_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int CNT_W      = 8,
  parameter int DEF_PERIOD = 10,
  parameter int DEF_HIGH   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  oneshot,
  input  logic                  cfg_load,
  input  logic [CNT_W-1:0]      period_in,
  input  logic [CNT_W-1:0]      high_in,
  output logic [NUM_PHASES-1:0] phase,
  output logic                  tick,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  if (NUM_PHASES < 1 || NUM_PHASES > MAX_PHASES) begin : g_bad_phases
    $error("osc_phase_gen: NUM_PHASES out of range");
  end
  if (CNT_W > MAX_CNT_W) begin : g_bad_width
    $error("osc_phase_gen: CNT_W too wide");
  end
  if (DEF_PERIOD < 2 || DEF_HIGH < 1 || NUM_PHASES * DEF_HIGH > DEF_PERIOD) begin : g_bad_default
    $error("osc_phase_gen: invalid default period/high");
  end

  localparam osc_cfg_t DEF_CFG = '{period: MAX_CNT_W'(DEF_PERIOD), high: MAX_CNT_W'(DEF_HIGH)};

  osc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  osc_cfg_t         active_q, active_d, shadow_q, shadow_d;
  logic             oneshot_q, oneshot_d;
  logic             hold_q, hold_d;
  logic             tick_q, tick_d, busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
  logic             last, run_d, restart, cfg_bad;
  logic [CNT_W+2:0] need;

  assign need    = (CNT_W+3)'(high_in) * (CNT_W+3)'(NUM_PHASES);
  assign cfg_bad = (period_in < CNT_W'(2)) || (high_in == '0) || (need > (CNT_W+3)'(period_in));
  assign last    = (MAX_CNT_W'(cnt_q) == active_q.period - MAX_CNT_W'(1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    active_d  = active_q;
    oneshot_d = oneshot_q;
    hold_d    = hold_q;
    shadow_d  = shadow_q;
    cfg_err_d = cfg_err_q;
    unique case (state_q)
      IDLE: begin
        if (enable && !hold_q) begin
          state_d   = RUN;
          cnt_d     = '0;
          active_d  = shadow_q;
          oneshot_d = oneshot;
        end
      end
      RUN: begin
        if (last) begin
          cnt_d = '0;
          if (!enable || oneshot_q) state_d = IDLE;
          else                      active_d = shadow_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (!enable || oneshot_q) state_d = STOP;
        end
      end
      STOP: begin
        if (last) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // a finished one-shot waits for enable to drop before it may re-arm
    if (state_q != IDLE && state_d == IDLE && oneshot_q) hold_d = 1'b1;
    if (!enable) hold_d = 1'b0;
    if (cfg_load) begin
      if (cfg_bad) begin
        cfg_err_d = 1'b1;
      end else begin
        shadow_d  = '{period: MAX_CNT_W'(period_in), high: MAX_CNT_W'(high_in)};
        cfg_err_d = 1'b0;
      end
    end
    run_d   = (state_d != IDLE);
    restart = (cnt_d == '0);
    tick_d  = run_d && restart;
    busy_d  = run_d;
    done_d  = (state_q != IDLE) && (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      active_q  <= DEF_CFG;
      shadow_q  <= DEF_CFG;
      oneshot_q <= 1'b0;
      hold_q    <= 1'b0;
      tick_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      oneshot_q <= oneshot_d;
      hold_q    <= hold_d;
      tick_q    <= tick_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  osc_phase_seq #(
    .NUM_PHASES(NUM_PHASES),
    .CNT_W     (CNT_W)
  ) u_seq (
    .clk    (clk),
    .reset  (reset),
    .run    (run_d),
    .restart(restart),
    .high   (active_q.high),
    .phase  (phase)
  );

  assign tick    = tick_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_osc_phase_gen.sv
// tb/tb_osc_phase_gen.sv - scoreboard bench for osc_phase_gen against a period-arithmetic model
module tb_osc_phase_gen;

  localparam int NP = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset, enable, oneshot, cfg_load;
  logic [CW-1:0] period_in, high_in;
  logic [NP-1:0] phase;
  logic          tick, busy, done, cfg_err;

  always #5 clk = ~clk;

  osc_phase_gen #(
    .NUM_PHASES(NP),
    .CNT_W     (CW),
    .DEF_PERIOD(10),
    .DEF_HIGH  (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .oneshot  (oneshot),
    .cfg_load (cfg_load),
    .period_in(period_in),
    .high_in  (high_in),
    .phase    (phase),
    .tick     (tick),
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err)
  );

  typedef struct {
    logic [NP-1:0] phase;
    logic          tick, busy, done, err;
    int            h;
    bit            rst;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  bit   stim_done = 0;

  bit m_run, m_stop, m_os, m_hold, m_err;
  int m_cnt, m_p, m_h, s_p, s_h;

  // Model: position in the period decides everything; phase k owns cnt/H == k.
  task automatic model(input bit en, input bit os, input bit ld, input int pin, input int hin, input bit rst);
    exp_t e;
    int   k;
    e.done = 1'b0;
    e.rst  = rst;
    if (rst) begin
      m_run = 0; m_stop = 0; m_os = 0; m_hold = 0; m_err = 0;
      m_cnt = 0; m_p = 10; m_h = 2; s_p = 10; s_h = 2;
    end else begin
      if (!m_run) begin
        if (en && !m_hold) begin
          m_run = 1; m_stop = 0; m_os = os; m_cnt = 0; m_p = s_p; m_h = s_h;
        end
      end else if (m_cnt == m_p - 1) begin
        if (m_stop || !en || m_os) begin
          m_run = 0; m_cnt = 0; e.done = 1'b1;
          if (m_os) m_hold = 1;
        end else begin
          m_cnt = 0; m_p = s_p; m_h = s_h;
        end
      end else begin
        m_cnt++;
        if (!en || m_os) m_stop = 1;
      end
      if (!en) m_hold = 0;
      if (ld) begin
        if (pin < 2 || hin == 0 || NP * hin > pin) m_err = 1;
        else begin s_p = pin; s_h = hin; m_err = 0; end
      end
    end
    e.phase = '0;
    k = m_cnt / m_h;
    if (m_run && k < NP) e.phase[k] = 1'b1;
    e.tick = m_run && (m_cnt == 0);
    e.busy = m_run;
    e.err  = m_err;
    e.h    = m_h;
    sbq.push_back(e);
  endtask

  task automatic step(input bit en, input bit os, input bit ld, input int pin, input int hin, input bit rst);
    @(negedge clk);
    enable    = en;
    oneshot   = os;
    cfg_load  = ld;
    period_in = CW'(pin);
    high_in   = CW'(hin);
    reset     = rst;
    model(en, os, ld, pin, hin, rst);
  endtask

  task automatic wait_cnt(input int target, input string tag);
    int i;
    for (i = 0; i < 64 && !(m_run && m_cnt == target); i++) step(1, 0, 0, 0, 0, 0);
    if (!(m_run && m_cnt == target)) begin
      checks++;
      errors++;
      $display("FAIL %s: cnt %0d not reached, model cnt=%0d", tag, target, m_cnt);
    end
  endtask

  task automatic run_stim();
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    repeat (35) step(1, 0, 0, 0, 0, 0);
    wait_cnt(3, "drop_at_3");
    repeat (16) step(0, 0, 0, 0, 0, 0);
    repeat (25) step(1, 1, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 8, 3, 0);
    repeat (15) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 16, 3, 0);
    repeat (40) step(1, 0, 0, 0, 0, 0);
    wait_cnt(5, "reset_at_5");
    step(1, 0, 0, 0, 0, 1);
    repeat (12) step(1, 0, 0, 0, 0, 0);
    wait_cnt(9, "load_at_wrap");
    step(1, 0, 1, 12, 3, 0);
    repeat (30) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 1, 0);
    step(1, 0, 1, 20, 0, 0);
    step(1, 0, 1, 200, 64, 0);
    repeat (20) step(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 4,
           $urandom_range(0, 40), $urandom_range(0, 12), $urandom_range(0, 999) < 5);
    end
    step(0, 0, 0, 0, 0, 0);
    stim_done = 1;
  endtask

  task automatic run_mon();
    exp_t e;
    int   len[NP];
    int   sh[NP];
    for (int k = 0; k < NP; k++) begin len[k] = 0; sh[k] = 0; end
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(posedge clk);
      #2;
      if (sbq.size() == 0) begin
        if (stim_done) break;
        continue;
      end
      e = sbq.pop_front();
      checks++;
      if ({phase, tick, busy, done, cfg_err} !== {e.phase, e.tick, e.busy, e.done, e.err}) begin
        errors++;
        $display("FAIL outs cyc=%0d actual phase=%b tick=%b busy=%b done=%b err=%b required phase=%b tick=%b busy=%b done=%b err=%b",
                 cyc, phase, tick, busy, done, cfg_err, e.phase, e.tick, e.busy, e.done, e.err);
      end
      checks++;
      if ($countones(phase) > 1) begin
        errors++;
        $display("FAIL onehot cyc=%0d actual phase=%b required at most one bit", cyc, phase);
      end
      for (int k = 0; k < NP; k++) begin
        if (e.rst) begin
          len[k] = 0;
        end else if (phase[k] === 1'b1) begin
          if (len[k] == 0) sh[k] = e.h;
          len[k]++;
        end else if (len[k] > 0) begin
          checks++;
          if (len[k] != sh[k]) begin
            errors++;
            $display("FAIL pulse_len cyc=%0d phase%0d actual=%0d required=%0d", cyc, k, len[k], sh[k]);
          end
          len[k] = 0;
        end
      end
    end
    if (!stim_done || sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL monitor_timeout actual pending=%0d required 0", sbq.size());
    end
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    oneshot   = 1'b0;
    cfg_load  = 1'b0;
    period_in = '0;
    high_in   = '0;
    fork
      run_stim();
      run_mon();
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
